// File: rtl/level_pkg.sv
// Shared types and constants for the level sequencer: FSM state encoding,
// default transition length and the full-screen colours used on win/lose.
package level_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRANS = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int          TRANS_FRAMES_DEF = 60;
    localparam logic [11:0] RGB_BLACK        = 12'h000;
    localparam logic [11:0] RGB_WIN          = 12'h0F0;
    localparam logic [11:0] RGB_OVER         = 12'hF00;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, sync/blank strobes and 12-bit rgb.
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/rise_det.sv
// Rising-edge detector: one-cycle pulse when d goes 0->1. RESET_VAL presets the
// history bit so a level already high at reset release can be masked.
module rise_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d;
        end
    end

    assign pulse = d & ~prev_q;

endmodule

// File: rtl/level_seq_ctrl.sv
// Game level sequencer: steps idle -> black transition -> level play -> win/over
// on frame ticks, and muxes the level renderers onto one registered VGA stream.
module level_seq_ctrl
    import level_pkg::*;
#(
    parameter int TRANS_FRAMES = TRANS_FRAMES_DEF,
    parameter int NUM_LEVELS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       level_done,
    input  logic       player_hit,
    vga_if.in          vga_lvl1,
    vga_if.in          vga_lvl2,
    vga_if.out         vga_out,
    output logic [1:0] level_id,
    output logic [2:0] state
);

    localparam int                 FRAME_W    = $clog2(TRANS_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(TRANS_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX  = FRAME_W'(TRANS_FRAMES);
    localparam logic [1:0]         LAST_LEVEL = 2'(NUM_LEVELS);

    state_t             state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [1:0]         next_level_q, next_level_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               done_pend_q, done_pend_d;
    logic               hit_pend_q, hit_pend_d;
    logic               frame_tick;
    logic               start_press;
    logic [11:0]        rgb_d;

    rise_det #(.RESET_VAL(1'b0)) u_vblnk_rise (
        .clk   (clk),
        .rst   (rst),
        .d     (vga_lvl1.vblnk),
        .pulse (frame_tick)
    );

    // History preset to 1 so a button held through reset is not a press.
    rise_det #(.RESET_VAL(1'b1)) u_start_rise (
        .clk   (clk),
        .rst   (rst),
        .d     (btn_start),
        .pulse (start_press)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        next_level_d = next_level_q;
        frame_cnt_d  = frame_cnt_q;
        done_pend_d  = done_pend_q;
        hit_pend_d   = hit_pend_q;

        if (state_q == S_PLAY) begin
            done_pend_d = done_pend_q | level_done;
            hit_pend_d  = hit_pend_q | player_hit;
        end

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d      = S_TRANS;
                    next_level_d = 2'd1;
                    frame_cnt_d  = '0;
                end
            end
            S_TRANS: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = S_PLAY;
                        level_d = next_level_q;
                    end
                    if (frame_cnt_q != FRAME_MAX) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (hit_pend_d) begin
                        state_d = S_OVER;
                    end else if (done_pend_d) begin
                        if (level_q < LAST_LEVEL) begin
                            state_d      = S_TRANS;
                            next_level_d = level_q + 2'd1;
                            frame_cnt_d  = '0;
                            level_d      = 2'd0;
                        end else begin
                            state_d = S_WIN;
                        end
                    end
                    done_pend_d = 1'b0;
                    hit_pend_d  = 1'b0;
                end
            end
            S_WIN, S_OVER: begin
                if (start_press) begin
                    state_d = S_IDLE;
                    level_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            done_pend_d = 1'b0;
            hit_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            level_q      <= 2'd0;
            next_level_q <= 2'd0;
            frame_cnt_q  <= '0;
            done_pend_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            next_level_q <= next_level_d;
            frame_cnt_q  <= frame_cnt_d;
            done_pend_q  <= done_pend_d;
            hit_pend_q   <= hit_pend_d;
        end
    end

    // Tick-driven state changes land on the first vblank cycle, so any rgb
    // source switch is already hidden behind blanking.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (!(vga_lvl1.hblnk || vga_lvl1.vblnk)) begin
            case (state_q)
                S_PLAY: begin
                    if (level_q == 2'd1) begin
                        rgb_d = vga_lvl1.rgb;
                    end else if (level_q == 2'd2) begin
                        rgb_d = vga_lvl2.rgb;
                    end
                end
                S_WIN:   rgb_d = RGB_WIN;
                S_OVER:  rgb_d = RGB_OVER;
                default: rgb_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= vga_lvl1.hcount;
            vga_out.vcount <= vga_lvl1.vcount;
            vga_out.hsync  <= vga_lvl1.hsync;
            vga_out.vsync  <= vga_lvl1.vsync;
            vga_out.hblnk  <= vga_lvl1.hblnk;
            vga_out.vblnk  <= vga_lvl1.vblnk;
            vga_out.rgb    <= rgb_d;
        end
    end

    assign level_id = level_q;
    assign state    = state_q;

endmodule
